ysyx_22040759_mdu: RTL and testbench
====================================

Name: ysyx_22040759_mdu

Overview:
Parametrised iterative multiply/divide unit implementing the full RV64M set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus W forms). It replaces the single-cycle `*`, `/` and `%` paths of the execute-stage ALU. It sits beside the ALU in EXU and uses a valid/ready handshake on both sides so the pipeline stalls while it iterates. Division by zero and signed overflow complete early, in one cycle.

Parameters:
XLEN, 64, operand/result width; legal values are 32 and 64. Word mode is only meaningful when XLEN=64.
WLEN, 32, operand width used in word (W) mode.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
flush  in  1  abort any operation in flight; synchronous
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
op  in  3  RISC-V funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
word  in  1  W-form instruction (mulw/divw/divuw/remw/remuw)
src_a  in  XLEN  rs1 value
src_b  in  XLEN  rs2 value
out_valid  out  1  result valid
out_ready  in  1  consumer takes the result
result  out  XLEN  result

Behaviour:
- States: IDLE, CALC, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Reset (rst_n=0, asynchronous): state=IDLE, out_valid=0, result=0, iteration counter=0, internal operand registers=0.
- Accept: on an edge with in_valid&in_ready, latch op, word and operands.
  - In word mode, use src[31:0]: sign-extend for signed ops, zero-extend for unsigned ops.
  - word with op 001/010/011 is executed as mulw (op forced to 000).
- N = WLEN if word, else XLEN.
- Early-out cases go IDLE->DONE on the accept edge, so latency is 1 cycle.
  - Divide by zero: div/divu give all-ones; rem/remu give the dividend.
  - Signed overflow (div with dividend=most-negative, divisor=-1): quotient = dividend, remainder = 0.
- Normal path goes IDLE->CALC. Each CALC edge performs one radix-2 iteration and increments the counter. The edge completing iteration N moves to DONE. out_valid is first high N cycles after the accept edge.
- Multiply:
  - Operands are converted to magnitudes, with signedness per op (mulhsu: a signed, b unsigned).
  - Shift-add into a 2N-bit accumulator; the product is negated at the end if the signs differ.
  - mul returns the low N bits; mulh* return the high N bits.
- Divide:
  - Restoring division on magnitudes.
  - The quotient is negated if the operand signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
- Word mode: result = sign-extension of the 32-bit result to XLEN, for both signed and unsigned ops.
- DONE: result is held stable while out_valid=1 and out_ready=0. When out_valid&out_ready on an edge: DONE->IDLE, out_valid drops.
  - There is no IDLE bypass: a new request can be accepted one cycle after the handshake, because in_ready is registered-state based.
- flush: has priority over everything. On the next edge, any state goes to IDLE, out_valid=0, and no request is accepted that edge even if in_valid=1. result is don't-care after flush.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at their reset values. No partial result is ever presented.
- result is driven from the internal register only in DONE; its value outside DONE is unspecified but must not be X after reset.

Test Plan:
1. XLEN=64, mul src_a=3, src_b=0xFFFF_FFFF_FFFF_FFFE (-2) -> result 0xFFFF_FFFF_FFFF_FFFA; out_valid exactly 64 cycles after the accept edge. mulhu with both operands all-ones -> 0xFFFF_FFFF_FFFF_FFFE. mulh -7×3 -> 0xFFFF_FFFF_FFFF_FFFF.
2. divu 7/0 -> 0xFFFF_FFFF_FFFF_FFFF and remu 7/0 -> 7, each with 1-cycle latency. div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, rem -> 0, both 1-cycle.
3. Signed division: div -7/2 -> -3 (0xFFFF_FFFF_FFFF_FFFD); rem -7/2 -> -1; rem 7/-2 -> 1; divu 100/7 -> 14, remu -> 2.
4. Word mode: mulw 0x7FFF_FFFF×2 -> 0xFFFF_FFFF_FFFF_FFFE with 32-cycle latency. divuw src_a=0x1_FFFF_FFFF, src_b=2 (upper bits ignored) -> 0x0000_0000_7FFF_FFFF. remw 0x8000_0000 / 0xFFFF_FFFF -> 0.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable and in_ready=0 throughout. A new in_valid is accepted only after the handshake; back-to-back ops produce correct independent results.
6. Flush at CALC iteration 20 -> IDLE next edge, out_valid never rises. Separately, deassert rst_n mid-CALC -> outputs reset immediately (asynchronously). After release, a fresh div 100/7 returns 14.

Source files
------------

// File: rtl/ysyx_22040759_mdu.sv
// rtl/ysyx_22040759_mdu.sv - iterative RV64M multiply/divide unit with valid/ready handshakes
module ysyx_22040759_mdu #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int SH = (XLEN > WLEN) ? XLEN - WLEN : 0;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        logic signed [XLEN-1:0] t;
        t = $signed(v << SH);
        return t >>> SH;
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
        return (v << SH) >> SH;
    endfunction

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_r;
    logic                word_r;
    logic                neg_p;
    logic                neg_r;
    logic [XLEN-1:0]     x_r;
    logic [2*XLEN-1:0]   mcand_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     result_r;
    logic                out_valid_r;

    logic                word_eff;
    logic [2:0]          op_eff;
    logic                a_signed;
    logic                b_signed;
    logic [XLEN-1:0]     a_ext;
    logic [XLEN-1:0]     b_ext;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN-1:0]     min_n;
    logic                is_div;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     early_res;

    // Request decode: operand extension, magnitudes and the one-cycle special cases
    always_comb begin
        word_eff  = word && (XLEN > WLEN);
        op_eff    = (word_eff && !op[2]) ? 3'b000 : op;
        a_signed  = !(op_eff[0] && (op_eff[1] || op_eff[2]));
        b_signed  = !(op_eff[2] ? op_eff[0] : op_eff[1]);
        a_ext     = word_eff ? (a_signed ? sext_w(src_a) : zext_w(src_a)) : src_a;
        b_ext     = word_eff ? (b_signed ? sext_w(src_b) : zext_w(src_b)) : src_b;
        a_neg     = a_signed && a_ext[XLEN-1];
        b_neg     = b_signed && b_ext[XLEN-1];
        a_mag     = a_neg ? -a_ext : a_ext;
        b_mag     = b_neg ? -b_ext : b_ext;
        min_n     = word_eff ? sext_w(XLEN'(1) << (WLEN - 1)) : (XLEN'(1) << (XLEN - 1));
        is_div    = op_eff[2];
        div_zero  = is_div && (b_ext == '0);
        div_ovf   = is_div && !op_eff[0] && (a_ext == min_n) && (b_ext == '1);
        early_res = '0;
        if (div_zero)
            early_res = op_eff[1] ? (word_eff ? sext_w(a_ext) : a_ext) : '1;
        else if (!op_eff[1])
            early_res = a_ext;
    end

    logic [2*XLEN-1:0]   mul_acc_n;
    logic [XLEN:0]       div_r;
    logic                div_ge;
    logic [XLEN-1:0]     rem_n;
    logic [XLEN-1:0]     q_n;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rmd;
    logic [XLEN-1:0]     fin_res;
    logic [CW-1:0]       last_iter;

    // One radix-2 step for each algorithm, plus sign fix-up used on the final step
    always_comb begin
        mul_acc_n = acc_r + (x_r[0] ? mcand_r : '0);
        div_r     = {acc_r[XLEN-1:0], x_r[XLEN-1]};
        div_ge    = div_r >= {1'b0, mcand_r[XLEN-1:0]};
        rem_n     = div_ge ? XLEN'(div_r - {1'b0, mcand_r[XLEN-1:0]}) : div_r[XLEN-1:0];
        q_n       = {x_r[XLEN-2:0], div_ge};
        prod      = neg_p ? -mul_acc_n : mul_acc_n;
        quo       = neg_p ? -q_n : q_n;
        rmd       = neg_r ? -rem_n : rem_n;
        case (op_r)
            3'b000:                 fin_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
            default:                fin_res = op_r[1] ? rmd : quo;
        endcase
        if (word_r)
            fin_res = sext_w(fin_res);
        last_iter = word_r ? CW'(WLEN - 1) : CW'(XLEN - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_r        <= '0;
            word_r      <= 1'b0;
            neg_p       <= 1'b0;
            neg_r       <= 1'b0;
            x_r         <= '0;
            mcand_r     <= '0;
            acc_r       <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= op_eff;
                        word_r <= word_eff;
                        cnt    <= '0;
                        acc_r  <= '0;
                        neg_p  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (div_zero || div_ovf) begin
                            result_r    <= early_res;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                            if (is_div) begin
                                // Left-align the dividend so its MSB enters the remainder first
                                x_r     <= a_mag << (word_eff ? SH : 0);
                                mcand_r <= {{XLEN{1'b0}}, b_mag};
                            end else begin
                                x_r     <= b_mag;
                                mcand_r <= {{XLEN{1'b0}}, a_mag};
                            end
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_r[2]) begin
                        acc_r <= {{XLEN{1'b0}}, rem_n};
                        x_r   <= q_n;
                    end else begin
                        acc_r   <= mul_acc_n;
                        mcand_r <= mcand_r << 1;
                        x_r     <= x_r >> 1;
                    end
                    if (cnt == last_iter) begin
                        result_r    <= fin_res;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign result    = out_valid_r ? result_r : '0;

endmodule

// File: tb/tb_ysyx_22040759_mdu.sv
// tb/tb_ysyx_22040759_mdu.sv - directed self-checking bench for ysyx_22040759_mdu
`timescale 1ns/1ps
module tb_ysyx_22040759_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic        word = 1'b0;
    logic [63:0] src_a = '0;
    logic [63:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int lat;
    logic seen_valid;

    ysyx_22040759_mdu #(.XLEN(64), .WLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input string tag, input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op = o; word = w; src_a = a; src_b = b; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
        int l;
        start(tag, o, w, a, b);
        wait_done(l);
        chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
        chk({tag, "_res"}, result, exp);
        handshake(tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("mul_3_m2", 3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 64);
        run("mulhu_ones", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run("mulh_m7_3", 3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64);

        run("divu_7_0", 3'b101, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run("remu_7_0", 3'b111, 1'b0, 64'd7, 64'd0, 64'd7, 0);
        run("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
        run("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0);

        run("div_m7_2", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
        run("rem_m7_2", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run("rem_7_m2", 3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64);
        run("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 64);
        run("remu_100_7", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 64);

        run("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);
        run("mulhw_as_mulw", 3'b001, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);
        run("divuw", 3'b101, 1'b1, 64'h1_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 32);
        run("remw_ovf", 3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0);
        run("divw_m7_2", 3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32);
        run("remuw_0", 3'b111, 1'b1, 64'h1_8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 0);

        // Backpressure with a competing request held on the input
        start("bp_div", 3'b100, 1'b0, 64'd100, 64'd7);
        wait_done(lat);
        chk("bp_lat", 64'(lat), 64'd64);
        op = 3'b000; word = 1'b0; src_a = 64'd5; src_b = 64'd6; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_res", result, 64'd14);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_drop", 64'(out_valid), 64'd0);
        chk("bp_idle_after_hs", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accepted", 64'(in_ready), 64'd0);
        wait_done(lat);
        chk("bp2_lat", 64'(lat), 64'd64);
        chk("bp2_res", result, 64'd30);
        handshake("bp2");

        // Flush after 20 iterations, with a request offered on the flush edge
        start("fl_mul", 3'b000, 1'b0, 64'd9, 64'd9);
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; op = 3'b101; src_a = 64'd8; src_b = 64'd2;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_idle", 64'(in_ready), 64'd1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        seen_valid = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("fl_never_valid", 64'(seen_valid), 64'd0);

        // Asynchronous reset in the middle of a division
        start("ar_div", 3'b100, 1'b0, 64'd100, 64'd7);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("ar_div_after", 3'b100, 1'b0, 64'd100, 64'd7, 64'd14, 64);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
